// File: rtl/wm_plant_responder.sv
// Plant-side responder for the washing-machine controller.
// It turns the controller's one-hot operation strobes into the status signals
// the controller waits on (tank full, temperature reached, phase complete,
// time-out, motor and balance faults). It also synchronises and conditions the
// raw lid, coin and cancel switches. Each phase is modelled by a duration
// counter, so the controller can run closed-loop with only switches attached.
module wm_plant_responder #(
    parameter int CNT_W          = 16,
    parameter int FILL_CYCLES    = 200,
    parameter int HEAT_CYCLES    = 300,
    parameter int WASH_CYCLES    = 1000,
    parameter int RINSE_CYCLES   = 600,
    parameter int SPIN_CYCLES    = 400,
    parameter int TIMEOUT_CYCLES = 500
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       fill_Water_Operation,
    input  logic       heat_Water_Operation,
    input  logic       wash_Operation,
    input  logic       rinse_Operation,
    input  logic       spin_Operation,
    input  logic       water_Intake,
    input  logic       supply_ok,
    input  logic       heater_ok,
    input  logic       lid_switch,
    input  logic       coin_in,
    input  logic       cancel_in,
    input  logic       motor_fault_inject,
    input  logic       imbalance_inject,
    output logic       sig_Lid_Closed,
    output logic       sig_Coin,
    output logic       sig_Cancel,
    output logic       sig_Full,
    output logic       sig_Temperature,
    output logic       sig_Wash_Completed,
    output logic       sig_Rinse_Completed,
    output logic       sig_Spin_Completed,
    output logic       sig_Time_Out,
    output logic       sig_Motor_Failure,
    output logic       sig_Out_Of_Balance,
    output logic       op_error,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_HEAT  = 3'd2,
        PH_WASH  = 3'd3,
        PH_RINSE = 3'd4,
        PH_SPIN  = 3'd5
    } phase_e;

    // Done flags, one per phase: {spin, rinse, wash, heat, fill}.
    localparam int D_FILL  = 0;
    localparam int D_HEAT  = 1;
    localparam int D_WASH  = 2;
    localparam int D_RINSE = 3;
    localparam int D_SPIN  = 4;

    phase_e           phase_q, phase_d, req_phase;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic [4:0]       done_q, done_d;
    logic             time_out_q, time_out_d;
    logic             motor_q, motor_d;
    logic             bal_q, bal_d;
    logic             op_error_q, op_error_d;

    logic [4:0]       ops;
    logic             cnt_en;
    logic [CNT_W-1:0] dur;
    logic [4:0]       done_mask;
    logic             watched;

    // Synchroniser chains: [0] first stage, [1] second stage, [2] edge history.
    logic [1:0] lid_sync_q, lid_sync_d;
    logic [2:0] coin_sync_q, coin_sync_d;
    logic [2:0] cancel_sync_q, cancel_sync_d;
    logic       coin_pulse_q, coin_pulse_d;
    logic       cancel_pulse_q, cancel_pulse_d;

    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

    // Decode the strobes into a requested phase; several strobes at once mean IDLE plus an error flag.
    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        req_phase  = PH_IDLE;
        op_error_d = 1'b0;
        ops = {spin_Operation, rinse_Operation, wash_Operation,
               heat_Water_Operation, fill_Water_Operation};
        case (ops)
            5'b00001: req_phase = PH_FILL;
            5'b00010: req_phase = PH_HEAT;
            5'b00100: req_phase = PH_WASH;
            5'b01000: req_phase = PH_RINSE;
            5'b10000: req_phase = PH_SPIN;
            default:  op_error_d = |(ops & (ops - 5'd1));
        endcase
    end

    // Per-phase counting enable, duration and done flag selection for the current phase.
    always_comb begin
        cnt_en    = 1'b0;
        dur       = '0;
        done_mask = '0;
        watched   = 1'b0;
        case (phase_q)
            PH_FILL: begin
                cnt_en    = water_Intake & supply_ok;
                dur       = CNT_W'(FILL_CYCLES);
                done_mask = 5'b1 << D_FILL;
                watched   = 1'b1;
            end
            PH_HEAT: begin
                cnt_en    = heater_ok;
                dur       = CNT_W'(HEAT_CYCLES);
                done_mask = 5'b1 << D_HEAT;
                watched   = 1'b1;
            end
            PH_WASH: begin
                cnt_en    = 1'b1;
                dur       = CNT_W'(WASH_CYCLES);
                done_mask = 5'b1 << D_WASH;
            end
            PH_RINSE: begin
                cnt_en    = water_Intake;
                dur       = CNT_W'(RINSE_CYCLES);
                done_mask = 5'b1 << D_RINSE;
            end
            PH_SPIN: begin
                cnt_en    = 1'b1;
                dur       = CNT_W'(SPIN_CYCLES);
                done_mask = 5'b1 << D_SPIN;
            end
            default: ;
        endcase
    end

    // Phase tracking, duration counter, watchdog and the done/fault/time-out flags.
    always_comb begin
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        wd_d       = wd_q;
        done_d     = done_q;
        time_out_d = time_out_q;
        motor_d    = 1'b0;
        bal_d      = 1'b0;
        if (req_phase != phase_q) begin
            // A phase change restarts the model; every status flag drops on the same edge.
            phase_d    = req_phase;
            cnt_d      = '0;
            wd_d       = '0;
            done_d     = '0;
            time_out_d = 1'b0;
        end else begin
            motor_d = motor_fault_inject & (phase_q == PH_RINSE || phase_q == PH_SPIN);
            bal_d   = imbalance_inject   & (phase_q == PH_WASH  || phase_q == PH_SPIN);
            if (cnt_en && cnt_q < dur) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == dur) begin
                    done_d = done_q | done_mask;
                end
            end
            // Done reached on the same edge as the watchdog limit takes priority.
            if (watched && wd_q < TO_LIM) begin
                wd_d = wd_q + CNT_W'(1);
                if (wd_d == TO_LIM && (done_d & done_mask) == '0) begin
                    time_out_d = 1'b1;
                end
            end
        end
    end

    // Two-flop synchronisers; coin and cancel add an edge-history flop and a registered rising-edge pulse.
    always_comb begin
        lid_sync_d     = {lid_sync_q[0], lid_switch};
        coin_sync_d    = {coin_sync_q[1:0], coin_in};
        cancel_sync_d  = {cancel_sync_q[1:0], cancel_in};
        coin_pulse_d   = coin_sync_q[1] & ~coin_sync_q[2];
        cancel_pulse_d = cancel_sync_q[1] & ~cancel_sync_q[2];
    end

    // State register with asynchronous clear of every flop, synchronisers included.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q        <= PH_IDLE;
            cnt_q          <= '0;
            wd_q           <= '0;
            done_q         <= '0;
            time_out_q     <= 1'b0;
            motor_q        <= 1'b0;
            bal_q          <= 1'b0;
            op_error_q     <= 1'b0;
            lid_sync_q     <= '0;
            coin_sync_q    <= '0;
            cancel_sync_q  <= '0;
            coin_pulse_q   <= 1'b0;
            cancel_pulse_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            phase_q        <= phase_d;
            cnt_q          <= cnt_d;
            wd_q           <= wd_d;
            done_q         <= done_d;
            time_out_q     <= time_out_d;
            motor_q        <= motor_d;
            bal_q          <= bal_d;
            op_error_q     <= op_error_d;
            lid_sync_q     <= lid_sync_d;
            coin_sync_q    <= coin_sync_d;
            cancel_sync_q  <= cancel_sync_d;
            coin_pulse_q   <= coin_pulse_d;
            cancel_pulse_q <= cancel_pulse_d;
        end
    end

    assign sig_Lid_Closed      = lid_sync_q[1];
    assign sig_Coin            = coin_pulse_q;
    assign sig_Cancel          = cancel_pulse_q;
    assign sig_Full            = done_q[D_FILL];
    assign sig_Temperature     = done_q[D_HEAT];
    assign sig_Wash_Completed  = done_q[D_WASH];
    assign sig_Rinse_Completed = done_q[D_RINSE];
    assign sig_Spin_Completed  = done_q[D_SPIN];
    assign sig_Time_Out        = time_out_q;
    assign sig_Motor_Failure   = motor_q;
    assign sig_Out_Of_Balance  = bal_q;
    assign op_error            = op_error_q;
    assign phase               = phase_q;

endmodule

// File: doc/wm_plant_responder.md
Name: wm_plant_responder

Overview:
- Responder for the washing-machine controller's operation outputs.
- Consumes the one-hot operation strobes and returns the sig_* status inputs the controller waits on: tank full, temperature reached, phase complete, time-out and motor/balance faults.
- Synchronises and conditions the raw lid, coin and cancel inputs.
- Duration counters model each phase, so the controller runs closed-loop in simulation and on FPGA with only switches attached.

Parameters:
- CNT_W, 16, width of the phase and watchdog counters.
- FILL_CYCLES, 200, enabled cycles needed to fill the tank.
- HEAT_CYCLES, 300, enabled cycles needed to reach temperature.
- WASH_CYCLES, 1000, cycles of wash.
- RINSE_CYCLES, 600, cycles of rinse.
- SPIN_CYCLES, 400, cycles of spin.
- TIMEOUT_CYCLES, 500, watchdog limit for fill and heat.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- fill_Water_Operation, heat_Water_Operation, wash_Operation, rinse_Operation, spin_Operation  in  1 each  operation strobes from the controller.
- water_Intake  in  1  water valve open.
- supply_ok  in  1  water supply present; gates fill progress.
- heater_ok  in  1  heater working; gates heat progress.
- lid_switch, coin_in, cancel_in  in  1 each  asynchronous raw inputs.
- motor_fault_inject, imbalance_inject  in  1 each  fault stimulus.
- sig_Lid_Closed, sig_Coin, sig_Cancel  out  1 each  conditioned inputs.
- sig_Full, sig_Temperature, sig_Wash_Completed, sig_Rinse_Completed, sig_Spin_Completed  out  1 each  phase done.
- sig_Time_Out, sig_Motor_Failure, sig_Out_Of_Balance  out  1 each  faults.
- op_error  out  1  more than one operation strobe high.
- phase  out  3  0=IDLE 1=FILL 2=HEAT 3=WASH 4=RINSE 5=SPIN.

Behaviour:
- Reset: asynchronous. All outputs 0, phase=IDLE, counters 0, synchroniser flops 0.
- All outputs are register outputs; there is no combinational path from inputs to outputs.

Phase decode:
- Each edge, the requested phase is the single high strobe.
- Zero strobes request IDLE.
- Two or more strobes request IDLE and set op_error=1 for that cycle.
- Requested phase differs from phase: phase updates, cnt=0, wd=0, all done/fault/time-out outputs clear on the same edge.

Counting, phase unchanged:
- cnt increments when the enable is true and cnt<DUR, then saturates at DUR.
  - FILL enable: water_Intake & supply_ok.
  - HEAT enable: heater_ok.
  - WASH/SPIN enable: always.
  - RINSE enable: water_Intake.
- Done output is set on the edge where cnt becomes DUR. It stays 1 until phase changes.
- Result: with the enable held high, done goes high exactly DUR edges after the edge that entered the phase.

Watchdog (FILL and HEAT only):
- wd increments every cycle, saturating at TIMEOUT_CYCLES.
- sig_Time_Out is set on the edge wd reaches TIMEOUT_CYCLES if done is still 0. It holds until phase changes.
- If done and time-out would set on the same edge, done wins and sig_Time_Out stays 0.

Faults:
- sig_Motor_Failure <= motor_fault_inject & phase∈{RINSE,SPIN}.
- sig_Out_Of_Balance <= imbalance_inject & phase∈{WASH,SPIN}.
- Latency is one cycle. They track the inject inputs at level and are forced 0 in other phases.

Input conditioning:
- lid_switch passes through a 2-flop synchroniser to sig_Lid_Closed: 2-edge latency, level.
- coin_in and cancel_in each pass through a 2-flop synchroniser plus a rising-edge detect register.
- sig_Coin/sig_Cancel are one-cycle pulses, high after the 3rd edge sampling the input high.
- No further pulse is produced until the input has been low for at least one synchronised sample.

Mid-operation reset:
- reset_n low at any time clears everything immediately.
- After release, the first edge behaves as from IDLE.

Test Plan:
- FILL_CYCLES=4, fill strobe high from edge 0, water_Intake=supply_ok=1 -> phase=1 after edge 0, sig_Full=1 after edge 4, sig_Time_Out stays 0.
- FILL_CYCLES=4, TIMEOUT_CYCLES=6, supply_ok=0 -> sig_Full=0, sig_Time_Out=1 after edge 6. Fill strobe drops -> both cleared next edge, phase=0.
- HEAT_CYCLES=TIMEOUT_CYCLES=5, heater_ok=1 -> sig_Temperature=1 and sig_Time_Out=0 after edge 5 (done priority).
- wash and spin strobes high together -> op_error=1, phase=0, no done output. Drop spin -> phase=3 next edge, op_error=0.
- Spin phase, imbalance_inject pulsed for 2 cycles -> sig_Out_Of_Balance high for exactly those 2 cycles delayed by 1. Same pulse in FILL -> stays 0.
- coin_in held high 10 cycles -> exactly one sig_Coin pulse, 3 edges after first high sample. reset_n low during WASH with cnt=500 -> all outputs 0 asynchronously, cnt=0.
